// File: rtl/ticket_pkg.sv
// ticket_pkg
// Shared definitions for the ticket dispense arbiter:
//   arb_state_t      - arbiter FSM state encoding
//   DEF_*            - default requester count and mechanism drive times
//   CNT_W            - width of the run-time down-counter (drive times up to 255)
//   run_load()       - counter preload for a run that must last 'cycles' cycles
package ticket_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN_DISP = 3'd1,
        ST_RUN_RTN  = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } arb_state_t;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_DISP_CYCLES = 8;
    localparam int DEF_RTN_CYCLES  = 4;
    localparam int CNT_W           = 8;

    // The counter counts down to zero inclusive, so a run of N cycles
    // starts from N-1.
    function automatic logic [CNT_W-1:0] run_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/rr_pick_nreq.sv
// rr_pick_nreq
// Combinational round-robin picker. Searches the pending vector starting at
// ptr+1 and wrapping around, so the last winner (ptr) has lowest priority.
// Ports:
//   pending - one bit per requester, high when that requester wants service
//   ptr     - index of the most recently granted requester
//   valid   - high when at least one requester is pending
//   winner  - index of the selected requester (0 when valid is low)
module rr_pick_nreq #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    // Walk offsets from farthest to nearest so the nearest pending index
    // after ptr is the last one written and therefore wins.
    always_comb begin
        logic [IW-1:0] idx;
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (pending[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/ticket_dispense_arbiter.sv
// ticket_dispense_arbiter
// Arbitrates a single shared ticket-dispense / money-return mechanism among
// NREQ ticket machines. A requester is chosen round-robin while idle, the
// mechanism is driven for a fixed number of cycles, and a one-cycle done
// pulse is returned to the owner. A mechanism jam aborts the operation.
// Ports:
//   clk           - clock, rising edge
//   clear_n       - asynchronous active-low reset
//   req_disp      - per-requester dispense request (level)
//   req_rtn       - per-requester money-return request (level)
//   mech_fault    - shared mechanism jam indication
//   grant         - one-hot owner of the mechanism
//   mech_dispense - drives the ticket dispenser
//   mech_return   - drives the money-return chute
//   done          - one-cycle completion pulse to the owner
//   busy          - high whenever the arbiter is not idle
//   fault         - high while the arbiter sits in the fault state
module ticket_dispense_arbiter
    import ticket_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int DISP_CYCLES = DEF_DISP_CYCLES,
    parameter int RTN_CYCLES  = DEF_RTN_CYCLES
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic [NREQ-1:0] req_disp,
    input  logic [NREQ-1:0] req_rtn,
    input  logic            mech_fault,
    output logic [NREQ-1:0] grant,
    output logic            mech_dispense,
    output logic            mech_return,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic            fault
);

    localparam int IW = $clog2(NREQ);

    arb_state_t       state;
    logic [CNT_W-1:0] count;
    logic [IW-1:0]    ptr;

    logic [NREQ-1:0]  pending;
    logic             pick_valid;
    logic [IW-1:0]    pick_winner;

    assign pending = req_disp | req_rtn;

    rr_pick_nreq #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    // Single FSM process. Every output is written here alongside the state
    // it belongs to, so outputs are registered and change together with the
    // state. ptr doubles as the index of the current owner during a run.
    // Requests are only looked at in IDLE; during a run the operation is
    // committed and finishes regardless of the request lines.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state         <= ST_IDLE;
            count         <= '0;
            ptr           <= IW'(NREQ - 1);
            grant         <= '0;
            done          <= '0;
            mech_dispense <= 1'b0;
            mech_return   <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        ptr   <= pick_winner;
                        grant <= NREQ'(1) << pick_winner;
                        busy  <= 1'b1;
                        // Dispense takes precedence when both requests are up.
                        if (req_disp[pick_winner]) begin
                            state         <= ST_RUN_DISP;
                            count         <= run_load(DISP_CYCLES);
                            mech_dispense <= 1'b1;
                        end else begin
                            state       <= ST_RUN_RTN;
                            count       <= run_load(RTN_CYCLES);
                            mech_return <= 1'b1;
                        end
                    end
                end

                ST_RUN_DISP, ST_RUN_RTN: begin
                    // A jam wins over completion, even on the final run cycle.
                    if (mech_fault) begin
                        state         <= ST_FAULT;
                        count         <= '0;
                        grant         <= '0;
                        mech_dispense <= 1'b0;
                        mech_return   <= 1'b0;
                        fault         <= 1'b1;
                    end else if (count == '0) begin
                        state         <= ST_DONE;
                        mech_dispense <= 1'b0;
                        mech_return   <= 1'b0;
                        done          <= grant;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end

                ST_FAULT: begin
                    if (!mech_fault) begin
                        state <= ST_IDLE;
                        fault <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    count         <= '0;
                    grant         <= '0;
                    mech_dispense <= 1'b0;
                    mech_return   <= 1'b0;
                    busy          <= 1'b0;
                    fault         <= 1'b0;
                end
            endcase
        end
    end

endmodule
